// File: rtl/updown_bounded_counter_pkg.sv
// Shared definitions for the bounded up/down counter: the encodings for
// counting direction and bound behaviour, used by the top and by the
// bound-check datapath.
package updown_bounded_counter_pkg;

    // Counting direction, as driven on up_not_down.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Behaviour when a step would cross a bound, as driven on saturate.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Default geometry of the general-purpose lab counter.
    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STEP_W = 8;

endpackage : updown_bounded_counter_pkg

// File: rtl/updown_bounded_counter_bound_check.sv
// Combinational next-value and bound-event computation for one count step.
// All arithmetic is one bit wider than the counter, so a step that would
// carry or borrow out of WIDTH bits is seen as a bound crossing rather than
// a modular wrap of the register.
module updown_bounded_counter_bound_check
    import updown_bounded_counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W
) (
    input  logic [WIDTH-1:0]  value,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit_lo,
    input  logic [WIDTH-1:0]  limit_hi,
    input  logic              up_not_down,
    input  logic              saturate,
    output logic [WIDTH-1:0]  next_value,
    output logic              upper_evt,
    output logic              lower_evt
);

    dir_e             dir;
    mode_e            mode;
    logic [WIDTH:0]   value_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   floor_ext;
    logic [WIDTH-1:0] diff;
    logic             cfg_ok;
    logic             step_nz;

    assign dir  = dir_e'(up_not_down);
    assign mode = mode_e'(saturate);

    // Widened operands: lo + step and value + step both fit in WIDTH+1 bits
    // because the step is never wider than the counter.
    assign value_ext = {1'b0, value};
    assign step_ext  = (WIDTH+1)'(step);
    assign hi_ext    = {1'b0, limit_hi};
    assign sum_ext   = value_ext + step_ext;
    assign floor_ext = {1'b0, limit_lo} + step_ext;

    // Only used when value >= lo + step, so it never borrows.
    assign diff = value - WIDTH'(step);

    // Inverted bounds freeze the counter; a zero step is a no-op that must
    // not report events even when the value sits outside the bounds.
    assign cfg_ok  = (limit_lo <= limit_hi);
    assign step_nz = |step;

    // Next value and event flags for an enabled count cycle; holds otherwise.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        next_value = value;
        upper_evt  = 1'b0;
        lower_evt  = 1'b0;
        if (cfg_ok && step_nz) begin
            if (dir == DIR_UP) begin
                // Only the upper bound is checked going up, so a value below
                // limit_lo climbs normally.
                if (sum_ext > hi_ext) begin
                    upper_evt  = 1'b1;
                    next_value = (mode == MODE_SAT) ? limit_hi : limit_lo;
                end else begin
                    next_value = sum_ext[WIDTH-1:0];
                end
            end else begin
                // value < lo + step is value - step < lo without any borrow.
                if (value_ext < floor_ext) begin
                    lower_evt  = 1'b1;
                    next_value = (mode == MODE_SAT) ? limit_lo : limit_hi;
                end else begin
                    next_value = diff;
                end
            end
        end
    end

endmodule : updown_bounded_counter_bound_check

// File: rtl/updown_bounded_counter.sv
// Parametrised up/down event/timer counter with run-time bounds, load with
// clamping, wrap or saturate at the bounds, a registered terminal-count
// pulse and sticky overflow/underflow flags. Edge priority is
// rst > load > count > hold.
module updown_bounded_counter
    import updown_bounded_counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              up_not_down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit_lo,
    input  logic [WIDTH-1:0]  limit_hi,
    input  logic              saturate,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  out_value,
    output logic              tc,
    output logic              ovf,
    output logic              unf
);

    logic [WIDTH-1:0] count_next;
    logic             upper_evt;
    logic             lower_evt;
    logic [WIDTH-1:0] load_clamped;
    logic             cfg_ok;

    // Next value and bound events for a count step from the current value.
    updown_bounded_counter_bound_check #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_bound_check (
        .value       (out_value),
        .step        (step),
        .limit_lo    (limit_lo),
        .limit_hi    (limit_hi),
        .up_not_down (up_not_down),
        .saturate    (saturate),
        .next_value  (count_next),
        .upper_evt   (upper_evt),
        .lower_evt   (lower_evt)
    );

    assign cfg_ok = (limit_lo <= limit_hi);

    // Clamp the load value into [limit_lo, limit_hi].
    always_comb begin
        load_clamped = load_value;
        if (load_value < limit_lo) begin
            load_clamped = limit_lo;
        end else if (load_value > limit_hi) begin
            load_clamped = limit_hi;
        end
    end

    // Counter, terminal-count and sticky-flag registers with priority
    // rst > load > count > hold; clr_flags applies in every non-reset cycle
    // but loses to a same-cycle event.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            out_value <= '0;
            tc        <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (load) begin
            if (cfg_ok) begin
                out_value <= load_clamped;
            end
            tc  <= 1'b0;
            ovf <= ovf & ~clr_flags;
            unf <= unf & ~clr_flags;
        end else if (en) begin
            out_value <= count_next;
            tc        <= upper_evt | lower_evt;
            ovf       <= upper_evt | (ovf & ~clr_flags);
            unf       <= lower_evt | (unf & ~clr_flags);
        end else begin
            tc  <= 1'b0;
            ovf <= ovf & ~clr_flags;
            unf <= unf & ~clr_flags;
        end
    end

endmodule : updown_bounded_counter

// File: tb/tb_updown_bounded_counter.sv
// Directed testbench for updown_bounded_counter at WIDTH=8, STEP_W=4.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the next rising edge.
module tb_updown_bounded_counter;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic              up_not_down;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit_lo;
    logic [WIDTH-1:0]  limit_hi;
    logic              saturate;
    logic              clr_flags;
    logic [WIDTH-1:0]  out_value;
    logic              tc;
    logic              ovf;
    logic              unf;

    int checks = 0;
    int errors = 0;

    updown_bounded_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_value  (load_value),
        .up_not_down (up_not_down),
        .step        (step),
        .limit_lo    (limit_lo),
        .limit_hi    (limit_hi),
        .saturate    (saturate),
        .clr_flags   (clr_flags),
        .out_value   (out_value),
        .tc          (tc),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; load_value = 8'h55; en = 1'b1; up_not_down = 1'b1;
        step = 4'd1; limit_lo = 8'd0; limit_hi = 8'd255; saturate = 1'b0; clr_flags = 1'b0;
        tick();
        checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out_value); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b expected 0", tc); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", unf); end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_wrap_up();
        limit_lo = 8'd10; limit_hi = 8'd20; step = 4'd3; up_not_down = 1'b1; saturate = 1'b0;
        load = 1'b1; load_value = 8'd18;
        tick();
        checks++; if (out_value !== 8'd18) begin errors++; $display("FAIL wrap_load: got %0d expected 18", out_value); end
        load = 1'b0; en = 1'b1;
        tick();
        checks++; if (out_value !== 8'd10) begin errors++; $display("FAIL wrap_out: got %0d expected 10", out_value); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL wrap_tc: got %b expected 1", tc); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got %b expected 1", ovf); end
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL wrap_unf: got %b expected 0", unf); end
        tick();
        checks++; if (out_value !== 8'd13) begin errors++; $display("FAIL wrap_next_out: got %0d expected 13", out_value); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL wrap_tc_one_cycle: got %b expected 0", tc); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf_sticky: got %b expected 1", ovf); end
        en = 1'b0;
        tick();
        checks++; if (out_value !== 8'd13) begin errors++; $display("FAIL hold_out: got %0d expected 13", out_value); end
    endtask

    task automatic test_saturate_down();
        limit_lo = 8'd10; limit_hi = 8'd20; step = 4'd5; up_not_down = 1'b0; saturate = 1'b1;
        load = 1'b1; load_value = 8'd12;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        checks++; if (out_value !== 8'd10) begin errors++; $display("FAIL sat_out: got %0d expected 10", out_value); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL sat_tc: got %b expected 1", tc); end
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL sat_unf: got %b expected 1", unf); end
        tick();
        checks++; if (out_value !== 8'd10) begin errors++; $display("FAIL sat_repeat_out: got %0d expected 10", out_value); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL sat_repeat_tc: got %b expected 1", tc); end
        en = 1'b0;
        tick();
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL sat_idle_tc: got %b expected 0", tc); end
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL sat_unf_sticky: got %b expected 1", unf); end
    endtask

    task automatic test_load_clamp();
        limit_lo = 8'd0; limit_hi = 8'd200; step = 4'd3; up_not_down = 1'b1; saturate = 1'b0;
        load = 1'b1; en = 1'b1; load_value = 8'd250;
        tick();
        checks++; if (out_value !== 8'd200) begin errors++; $display("FAIL clamp_hi_out: got %0d expected 200", out_value); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL clamp_hi_tc: got %b expected 0", tc); end
        limit_lo = 8'd10; load_value = 8'd5;
        tick();
        checks++; if (out_value !== 8'd10) begin errors++; $display("FAIL clamp_lo_out: got %0d expected 10", out_value); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_full_range();
        limit_lo = 8'd0; limit_hi = 8'd255; saturate = 1'b0;
        load = 1'b1; load_value = 8'd254;
        tick();
        load = 1'b0; en = 1'b1; up_not_down = 1'b1; step = 4'd3;
        tick();
        checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL full_up_out: got %0d expected 0", out_value); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_up_ovf: got %b expected 1", ovf); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL full_up_tc: got %b expected 1", tc); end
        up_not_down = 1'b0; step = 4'd1;
        tick();
        checks++; if (out_value !== 8'd255) begin errors++; $display("FAIL full_down_out: got %0d expected 255", out_value); end
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL full_down_unf: got %b expected 1", unf); end
        en = 1'b0;
    endtask

    task automatic test_clr_flags();
        load = 1'b1; load_value = 8'd254;
        tick();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL load_keeps_ovf: got %b expected 1", ovf); end
        load = 1'b0; en = 1'b1; up_not_down = 1'b1; step = 4'd3; clr_flags = 1'b1;
        tick();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clr_vs_event_ovf: got %b expected 1", ovf); end
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL clr_unf: got %b expected 0", unf); end
        checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL clr_event_out: got %0d expected 0", out_value); end
        en = 1'b0;
        tick();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_alone_ovf: got %b expected 0", ovf); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL clr_alone_tc: got %b expected 0", tc); end
        clr_flags = 1'b0;
    endtask

    task automatic test_step_zero();
        limit_lo = 8'd10; limit_hi = 8'd20; step = 4'd0; up_not_down = 1'b0; en = 1'b1;
        tick();
        checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL step0_down_out: got %0d expected 0", out_value); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL step0_down_tc: got %b expected 0", tc); end
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL step0_down_unf: got %b expected 0", unf); end
        up_not_down = 1'b1;
        tick();
        checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL step0_up_out: got %0d expected 0", out_value); end
        en = 1'b0;
    endtask

    task automatic test_out_of_bounds();
        limit_lo = 8'd50; limit_hi = 8'd100; step = 4'd5; up_not_down = 1'b1; en = 1'b1;
        tick();
        checks++; if (out_value !== 8'd5) begin errors++; $display("FAIL below_lo_up_out: got %0d expected 5", out_value); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL below_lo_up_tc: got %b expected 0", tc); end
        up_not_down = 1'b0; step = 4'd1; saturate = 1'b1;
        tick();
        checks++; if (out_value !== 8'd50) begin errors++; $display("FAIL below_lo_down_out: got %0d expected 50", out_value); end
        checks++; if (unf !== 1'b1) begin errors++; $display("FAIL below_lo_down_unf: got %b expected 1", unf); end
        en = 1'b0;
    endtask

    task automatic test_illegal_bounds();
        limit_lo = 8'd30; limit_hi = 8'd20; step = 4'd1; up_not_down = 1'b1; en = 1'b1;
        tick();
        checks++; if (out_value !== 8'd50) begin errors++; $display("FAIL illegal_count_out: got %0d expected 50", out_value); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL illegal_count_tc: got %b expected 0", tc); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL illegal_count_ovf: got %b expected 0", ovf); end
        load = 1'b1; load_value = 8'd25;
        tick();
        checks++; if (out_value !== 8'd50) begin errors++; $display("FAIL illegal_load_out: got %0d expected 50", out_value); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        limit_lo = 8'd0; limit_hi = 8'd51; step = 4'd1; up_not_down = 1'b1; saturate = 1'b0; en = 1'b1;
        tick();
        checks++; if (out_value !== 8'd51) begin errors++; $display("FAIL pre_reset_out: got %0d expected 51", out_value); end
        rst = 1'b1;
        tick();
        checks++; if (out_value !== 8'd0) begin errors++; $display("FAIL midreset_out: got %0d expected 0", out_value); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL midreset_tc: got %b expected 0", tc); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midreset_ovf: got %b expected 0", ovf); end
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL midreset_unf: got %b expected 0", unf); end
        rst = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_load_clamp();
        test_full_range();
        test_clr_flags();
        test_step_zero();
        test_out_of_bounds();
        test_illegal_bounds();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_updown_bounded_counter
